// File: rtl/sram_read_streamer_if.sv
// Command and stream bundle for sram_read_streamer.
//   cmd_*    : burst command (start address, word count), valid/ready handshake.
//   stream_* : returned read words, valid/ready handshake with last flag.
// Optional macro SRAM_STREAM_STRIDE_EN adds cmd_stride_i (address step per word).
// Modports: master = command producer / stream consumer, slave = the streamer.
interface sram_read_streamer_if #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned NUM_BIT = 32
);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [ADDR_W-1:0]  cmd_addr_i;
  logic [LEN_W-1:0]   cmd_len_i;
`ifdef SRAM_STREAM_STRIDE_EN
  logic [ADDR_W-1:0]  cmd_stride_i;
`endif
  logic               stream_valid_o;
  logic               stream_ready_i;
  logic [NUM_BIT-1:0] stream_data_o;
  logic               stream_last_o;

`ifdef SRAM_STREAM_STRIDE_EN
  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_stride_i, stream_ready_i,
    input  cmd_ready_o, stream_valid_o, stream_data_o, stream_last_o
  );
  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_stride_i, stream_ready_i,
    output cmd_ready_o, stream_valid_o, stream_data_o, stream_last_o
  );
`else
  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, stream_ready_i,
    input  cmd_ready_o, stream_valid_o, stream_data_o, stream_last_o
  );
  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, stream_ready_i,
    output cmd_ready_o, stream_valid_o, stream_data_o, stream_last_o
  );
`endif
endinterface

// File: rtl/sram_read_streamer.sv
// Read-side front end for a single-port SRAM macro (default 2048x32).
// Takes a burst command, issues one read per cycle through the active-low
// CEB/WEB/A pins, absorbs the 1-cycle read latency and returns the words as a
// valid/ready stream with a last flag. A small output FIFO plus a credit check
// gives full backpressure without ever dropping a word already in flight.
//
// Ports:
//   CLK, RST    clock, asynchronous active-high reset
//   bus         sram_read_streamer_if.slave (cmd_* in, stream_* out)
//   busy_o      burst in progress (ISSUE/DRAIN/DONE)
//   done_o      one-cycle pulse when a burst completes
//   CEB/WEB/A/D SRAM control, address and (tied-off) write data
//   Q           SRAM read data, valid the cycle after CEB=0
//
// Optional feature: define SRAM_STREAM_STRIDE_EN to enable bus.cmd_stride_i;
// otherwise the address step is fixed at 1.
module sram_read_streamer #(
  parameter int unsigned  NUM_WORD   = 2048,
  parameter int unsigned  NUM_BIT    = 32,
  parameter int unsigned  LEN_W      = 12,
  parameter int unsigned  FIFO_DEPTH = 2,
  localparam int unsigned ADDR_W     = $clog2(NUM_WORD)
) (
  input  logic                CLK,
  input  logic                RST,
  sram_read_streamer_if.slave bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                CEB,
  output logic                WEB,
  output logic [ADDR_W-1:0]   A,
  output logic [NUM_BIT-1:0]  D,
  input  logic [NUM_BIT-1:0]  Q
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_LIM    = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] NUM_WORD_LIM = (ADDR_W + 1)'(NUM_WORD);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    issue_rem_q;  // reads still to issue
  logic [LEN_W-1:0]    out_rem_q;    // words still to hand to the consumer
  logic                pending_q;    // a read was issued last cycle; Q is valid now
  logic [ADDR_W-1:0]   stride;

  logic [NUM_BIT-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    fifo_cnt_q;

  logic                stream_valid;
  logic                pop;
  logic                issue;
  logic [CNT_W:0]      outstanding;
  logic [ADDR_W:0]     addr_sum;
  logic [ADDR_W-1:0]   addr_next;

`ifdef SRAM_STREAM_STRIDE_EN
  logic [ADDR_W-1:0]   stride_q;
  assign stride = stride_q;
`else
  assign stride = ADDR_W'(1);
`endif

  always_comb begin
    stream_valid = (fifo_cnt_q != '0);
    pop          = stream_valid & bus.stream_ready_i;
    // Buffered words plus the read landing this cycle, minus the word leaving.
    // Issuing only below FIFO_DEPTH guarantees every in-flight Q has a slot.
    outstanding  = {1'b0, fifo_cnt_q} + (CNT_W + 1)'(pending_q) - (CNT_W + 1)'(pop);
    issue        = (state_q == StIssue) && (outstanding < DEPTH_LIM);
    addr_sum     = {1'b0, addr_q} + {1'b0, stride};
    addr_next    = addr_sum[ADDR_W-1:0];
    if (addr_sum >= NUM_WORD_LIM) begin
      addr_next = ADDR_W'(addr_sum - NUM_WORD_LIM);
    end
  end

  // Burst control FSM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      pending_q   <= 1'b0;
`ifdef SRAM_STREAM_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      pending_q <= issue;
      if (pop) begin
        out_rem_q <= out_rem_q - LEN_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid_i) begin
            addr_q      <= bus.cmd_addr_i;
            issue_rem_q <= bus.cmd_len_i;
            out_rem_q   <= bus.cmd_len_i;
`ifdef SRAM_STREAM_STRIDE_EN
            stride_q    <= bus.cmd_stride_i;
`endif
            state_q     <= (bus.cmd_len_i == '0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          if (issue) begin
            addr_q      <= addr_next;
            issue_rem_q <= issue_rem_q - LEN_W'(1);
            if (issue_rem_q == LEN_W'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && (out_rem_q == LEN_W'(1))) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output FIFO: pushed from Q only in the cycle after an issue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (pending_q) begin
        fifo_mem_q[wr_ptr_q] <= Q;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      unique case ({pending_q, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign bus.cmd_ready_o    = (state_q == StIdle);
  assign bus.stream_valid_o = stream_valid;
  assign bus.stream_data_o  = fifo_mem_q[rd_ptr_q];
  assign bus.stream_last_o  = stream_valid && (out_rem_q == LEN_W'(1));
  assign busy_o             = (state_q != StIdle);
  assign done_o             = (state_q == StDone);
  assign CEB                = ~issue;
  assign WEB                = 1'b1;
  assign A                  = addr_q;
  assign D                  = '0;

endmodule

// File: tb/tb_sram_read_streamer.sv
// Directed bench for sram_read_streamer with a behavioural 1-cycle-latency SRAM.
module tb_sram_read_streamer;

  logic        clk;
  logic        rst;
  logic        busy;
  logic        done;
  logic        ceb;
  logic        web;
  logic [10:0] a;
  logic [31:0] d;
  logic [31:0] q;

  sram_read_streamer_if #(.ADDR_W(11), .LEN_W(12), .NUM_BIT(32)) bus ();

  sram_read_streamer #(
    .NUM_WORD   (2048),
    .NUM_BIT    (32),
    .LEN_W      (12),
    .FIFO_DEPTH (2)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .bus    (bus),
    .busy_o (busy),
    .done_o (done),
    .CEB    (ceb),
    .WEB    (web),
    .A      (a),
    .D      (d),
    .Q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [10:0] addr);
    return 32'hC0DE_0000 | {21'h0, addr};
  endfunction

  // Q carries garbage whenever no read was issued, so a stray capture shows up.
  always @(posedge clk) begin
    if (!ceb) q <= sram_word(a);
    else      q <= 32'hDEAD_BEEF;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] cap_a[$];
  logic [31:0] cap_d[$];
  logic [31:0] cap_last[$];
  int first_ceb, last_ceb, first_valid, done_cyc, done_cnt, max_out;

  // Cycle 1 is the cycle after the command handshake edge.
  task automatic run_burst(input logic [10:0] addr, input logic [11:0] len,
                           input logic [10:0] stride, input logic [3:0] pat,
                           input int budget);
    int          issued;
    int          popped;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [10:0] ea;
    cap_a.delete();
    cap_d.delete();
    cap_last.delete();
    first_ceb = -1; last_ceb = -1; first_valid = -1; done_cyc = -1;
    done_cnt = 0; max_out = 0; issued = 0; popped = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i    = 1'b1;
    bus.cmd_addr_i     = addr;
    bus.cmd_len_i      = len;
`ifdef SRAM_STREAM_STRIDE_EN
    bus.cmd_stride_i   = stride;
`endif
    bus.stream_ready_i = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      bus.cmd_valid_i    = 1'b0;
      bus.stream_ready_i = pat[cyc % 4];
      #1;
      if (cyc == 1) begin
        check_eq("busy_in_burst", 32'(busy), 32'd1);
        check_eq("cmd_ready_in_burst", 32'(bus.cmd_ready_o), 32'd0);
      end
      if (!ceb) begin
        cap_a.push_back(32'(a));
        issued++;
        if (first_ceb < 0) first_ceb = cyc;
        last_ceb = cyc;
      end
      if (bus.stream_valid_o && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        check_eq("stall_data_stable", bus.stream_data_o, prev_data);
        check_eq("stall_last_stable", 32'(bus.stream_last_o), 32'(prev_last));
      end
      if (bus.stream_valid_o && bus.stream_ready_i) begin
        cap_d.push_back(bus.stream_data_o);
        cap_last.push_back(32'(bus.stream_last_o));
        popped++;
      end
      prev_stall = bus.stream_valid_o && !bus.stream_ready_i;
      prev_data  = bus.stream_data_o;
      prev_last  = bus.stream_last_o;
      if (issued - popped > max_out) max_out = issued - popped;
      if (done_cyc >= 0) begin
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("cmd_ready_after_done", 32'(bus.cmd_ready_o), 32'd1);
        check_eq("busy_after_done", 32'(busy), 32'd0);
        break;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    bus.stream_ready_i = 1'b1;
    check_eq("done_seen", 32'(done_cnt), 32'd1);
    check_eq("issue_count", 32'(cap_a.size()), 32'(len));
    check_eq("word_count", 32'(cap_d.size()), 32'(len));
    check_eq("max_outstanding_le_depth", 32'(max_out <= 2), 32'd1);
    ea = addr;
    for (int i = 0; i < cap_d.size(); i++) begin
      if (i < cap_a.size()) check_eq("issue_addr", cap_a[i], 32'(ea));
      check_eq("word_data", cap_d[i], sram_word(ea));
      check_eq("word_last", cap_last[i], 32'(i == int'(len) - 1));
      ea = ea + stride;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst                = 1'b1;
    bus.cmd_valid_i    = 1'b0;
    bus.cmd_addr_i     = '0;
    bus.cmd_len_i      = '0;
`ifdef SRAM_STREAM_STRIDE_EN
    bus.cmd_stride_i   = 11'd1;
`endif
    bus.stream_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check_eq("rst_ceb", 32'(ceb), 32'd1);
    check_eq("rst_web", 32'(web), 32'd1);
    check_eq("rst_a", 32'(a), 32'd0);
    check_eq("rst_d", d, 32'd0);
    check_eq("rst_valid", 32'(bus.stream_valid_o), 32'd0);
    check_eq("rst_last", 32'(bus.stream_last_o), 32'd0);
    check_eq("rst_data", bus.stream_data_o, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic burst: reads in cycles 1-4, words in 3-6, done in 7.
    run_burst(11'h010, 12'd4, 11'd1, 4'b1111, 40);
    check_eq("basic_first_ceb", 32'(first_ceb), 32'd1);
    check_eq("basic_last_ceb", 32'(last_ceb), 32'd4);
    check_eq("basic_first_valid", 32'(first_valid), 32'd3);
    check_eq("basic_done_cyc", 32'(done_cyc), 32'd7);
    check_eq("basic_a3", cap_a[3], 32'h013);

    // Backpressure, ready pattern 1,0,0,1 repeating.
    run_burst(11'h040, 12'd8, 11'd1, 4'b1001, 100);

    // Address wrap.
    run_burst(11'h7FE, 12'd4, 11'd1, 4'b1111, 40);
    check_eq("wrap_a1", cap_a[1], 32'h7FF);
    check_eq("wrap_a2", cap_a[2], 32'h000);
    check_eq("wrap_a3", cap_a[3], 32'h001);

    // Zero length.
    run_burst(11'h123, 12'd0, 11'd1, 4'b1111, 20);
    check_eq("zero_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
    check_eq("zero_no_ceb", 32'(first_ceb), 32'hFFFF_FFFF);
    check_eq("zero_done_cyc", 32'(done_cyc), 32'd1);

    // Reset in the middle of a 16-word burst.
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = 11'h200;
    bus.cmd_len_i   = 12'd16;
    repeat (3) begin
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
    end
    #1;
    check_eq("pre_rst_ceb", 32'(ceb), 32'd0);
    check_eq("pre_rst_valid", 32'(bus.stream_valid_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ceb", 32'(ceb), 32'd1);
    check_eq("mid_rst_valid", 32'(bus.stream_valid_o), 32'd0);
    check_eq("mid_rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_burst(11'h020, 12'd2, 11'd1, 4'b1111, 40);

`ifdef SRAM_STREAM_STRIDE_EN
    run_burst(11'h100, 12'd3, 11'h004, 4'b1111, 40);
    check_eq("stride_a1", cap_a[1], 32'h104);
    check_eq("stride_a2", cap_a[2], 32'h108);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_read_streamer.md
Name: sram_read_streamer

Overview:
- Read-side front end of the MAC engine's 2048x32 SRAM macro wrapper; sits directly upstream of it.
- Accepts a burst command (start address, word count) and drives the SRAM's active-low CEB/WEB/A pins.
- Absorbs the SRAM's fixed 1-cycle read latency and returns words as a valid/ready stream with last flag.
- Small output FIFO provides full backpressure without losing in-flight read data.

Parameters:
- NUM_WORD, 2048, SRAM depth in words.
- NUM_BIT, 32, SRAM word width.
- LEN_W, 12, width of burst length field.
- FIFO_DEPTH, 2, output buffer entries; minimum 2.
- ADDR_W, $clog2(NUM_WORD), derived; not to be overridden.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  burst command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_addr_i  in  ADDR_W  start word address.
- cmd_len_i  in  LEN_W  number of words; 0 legal.
- stream_valid_o  out  1  output word valid.
- stream_ready_i  in  1  consumer ready.
- stream_data_o  out  NUM_BIT  read word.
- stream_last_o  out  1  final word of burst.
- busy_o  out  1  burst in progress.
- done_o  out  1  one-cycle pulse at burst completion.
- CEB  out  1  SRAM chip enable, active low.
- WEB  out  1  SRAM write enable, active low; tied 1.
- A  out  ADDR_W  SRAM address.
- D  out  NUM_BIT  SRAM write data; tied 0.
- Q  in  NUM_BIT  SRAM read data, valid one cycle after CEB=0.

Behaviour:
- Reset values:
  - cmd_ready_o=1; CEB=1; WEB=1; A=0; D=0.
  - stream_valid_o=0; stream_last_o=0; stream_data_o=0; busy_o=0; done_o=0.
  - FIFO empty; read-pending flag cleared.
- FSM states:
  - IDLE: cmd_ready_o=1. On cmd handshake, latch addr and len. len>0 -> ISSUE; len=0 -> DONE.
  - ISSUE: one read per cycle when credit allows. Remaining-issue counter decrements per read; after the last issue -> DRAIN.
  - DRAIN: no new reads. When the last word completes its stream handshake -> DONE.
  - DONE: done_o=1 for exactly one cycle, then -> IDLE.
- busy_o=1 in ISSUE, DRAIN and DONE.
- cmd_ready_o=1 only in IDLE, so no command overlap.
- Read issue:
  - CEB=0 with A=current address for exactly the cycles a read is issued.
  - Address increments by 1 and wraps NUM_WORD-1 -> 0.
- Credit rule: issue only if (fifo_count + read_pending - pop_this_cycle) < FIFO_DEPTH. This guarantees no overflow and no dropped Q.
- Capture: a registered read_pending flag (= issued last cycle) writes Q into the FIFO at the end of the cycle Q is valid. The Q pin is never sampled otherwise.
- Latency, with stream_ready_i=1:
  - cmd handshake at edge 0.
  - CEB=0 in cycle 1; Q valid in cycle 2.
  - stream_valid_o=1 in cycle 3.
  - Steady state: 1 word/cycle.
- Stream rules:
  - stream_data_o and stream_last_o stay stable while valid&!ready.
  - stream_last_o=1 only on word index len-1.
- Simultaneous FIFO push and pop is allowed; count is unchanged.
- len=max (2^LEN_W - 1) is legal and may wrap the address space.
- RST asserted mid-burst: immediate return to IDLE with reset values. CEB goes high asynchronously and in-flight data is discarded.

Optional Feature:
- Macro SRAM_STREAM_STRIDE_EN.
- Defined:
  - Extra port cmd_stride_i, input, ADDR_W bits, latched at command accept.
  - Address advances by the stride modulo NUM_WORD.
  - Stride 0 rereads the same word len times.
- Undefined: port absent; stride fixed at 1.

Test Plan:
- Basic burst: cmd addr=0x010, len=4, ready=1 -> CEB low cycles 1-4 with A=0x010..0x013; data on stream cycles 3-6; last on 4th word; done_o pulse on the cycle after the last handshake.
- Backpressure: len=8, stream_ready_i toggling 1,0,0,1,... -> all 8 words delivered in order, no duplicates; never more than FIFO_DEPTH outstanding (buffered + in-flight); CEB high while credit is exhausted.
- Wrap: addr=0x7FE, len=4 -> A sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Zero length: len=0 -> CEB never low; no stream_valid_o; done_o pulses one cycle after accept; cmd_ready_o returns to 1.
- Reset mid-burst: RST asserted during ISSUE of a len=16 burst -> CEB=1, stream_valid_o=0, cmd_ready_o=1 immediately. A new len=2 burst afterwards completes normally.
- Stride (with SRAM_STREAM_STRIDE_EN): addr=0x100, stride=0x004, len=3 -> A = 0x100, 0x104, 0x108.
